// File: rtl/sync_w2r_mon_if.sv
// Write-to-read pointer sync bundle: FIFO read side drives the master end,
// the synchroniser/monitor sits on the slave end.
interface sync_w2r_mon_if #(
  parameter int PW = 4
);
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr_bin;
  logic          clr_err;
  logic [PW-1:0] rsync_ptr;
  logic [PW-1:0] rsync_bin;
  logic [PW-1:0] rfill;
  logic          rempty;
  logic          ralmost_empty;
  logic          wptr_adv;
  logic          gray_err;

  modport master (
    output wptr, rptr_bin, clr_err,
    input  rsync_ptr, rsync_bin, rfill, rempty, ralmost_empty, wptr_adv, gray_err
  );

  modport slave (
    input  wptr, rptr_bin, clr_err,
    output rsync_ptr, rsync_bin, rfill, rempty, ralmost_empty, wptr_adv, gray_err
  );
endinterface

// File: rtl/sync_w2r_mon.sv
// Gray write pointer into r_clk: SYNC_STAGES flops, registered binary decode,
// fill/empty against the local read pointer, and a sticky Gray-violation monitor.
module sync_w2r_mon #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input logic           r_clk,
  input logic           rst_n,
  sync_w2r_mon_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AE_W = PW'(AE_THRESH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_w2r_mon: SYNC_STAGES must be 2..4");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_w2r_mon: DEPTH must be a power of two >= 2");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
    $error("sync_w2r_mon: AE_THRESH must be 0..DEPTH");
  end

  logic [SYNC_STAGES-1:0][PW-1:0] r_sync;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_gprev;
  logic          r_adv;
  logic          r_err;
  logic [PW-1:0] w_g;
  logic [PW-1:0] w_bin;
  logic [PW-1:0] w_fill;
  logic          w_viol;

  assign w_g = r_sync[SYNC_STAGES-1];

  // bin[i] is the XOR of all Gray bits at or above i
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < PW; i++) w_bin[i] = ^(w_g >> i);
  end

  assign w_viol = $countones(w_g ^ r_gprev) > 1;

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_bin   <= '0;
      r_gprev <= '0;
      r_adv   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync[0] <= bus.wptr;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_bin   <= w_bin;
      r_gprev <= w_g;
      r_adv   <= (w_g != r_gprev);
      // a fresh violation beats a concurrent clear
      if (w_viol)           r_err <= 1'b1;
      else if (bus.clr_err) r_err <= 1'b0;
    end
  end

  // modulo subtraction handles pointer wrap; over-range fill is passed through
  assign w_fill            = r_bin - bus.rptr_bin;
  assign bus.rsync_ptr     = w_g;
  assign bus.rsync_bin     = r_bin;
  assign bus.rfill         = w_fill;
  assign bus.rempty        = (r_bin == bus.rptr_bin);
  assign bus.ralmost_empty = (w_fill <= AE_W);
  assign bus.wptr_adv      = r_adv;
  assign bus.gray_err      = r_err;
endmodule

// File: doc/sync_w2r_mon.md
Name: sync_w2r_mon

Overview:
Parametrised write-to-read pointer synchroniser for the async FIFO, and successor to the fixed two-flop version. It brings the Gray-coded write pointer into the r_clk domain through SYNC_STAGES flops, then decodes it to binary. It derives fill level, empty and almost-empty against the local binary read pointer. It also monitors the synchronised stream for Gray-code violations and flags them with a sticky error.

Parameters:
DEPTH, 8, FIFO depth in words; power of two, minimum 2; AW = $clog2(DEPTH), pointer width PW = AW+1.
SYNC_STAGES, 2, synchroniser flop count; legal range 2..4; out-of-range values are a compile-time error.
AE_THRESH, 1, almost-empty threshold in words; legal range 0..DEPTH.

Ports:
r_clk  input  1  read-domain clock; all flops are rising-edge.
rst_n  input  1  asynchronous active-low reset.
wptr  input  PW  Gray-coded write pointer, registered in the write domain.
rptr_bin  input  PW  local binary read pointer.
clr_err  input  1  synchronous clear of gray_err.
rsync_ptr  output  PW  last synchroniser stage (Gray).
rsync_bin  output  PW  registered binary decode of rsync_ptr.
rfill  output  PW  words available.
rempty  output  1  FIFO empty.
ralmost_empty  output  1  fill at or below threshold.
wptr_adv  output  1  one-cycle pulse when the synchronised pointer changed.
gray_err  output  1  sticky Gray-violation flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - cleared: all sync stages, rsync_bin, the internal gprev register, wptr_adv, gray_err.
  - rsync_ptr=0, rsync_bin=0.
  - The combinational outputs follow from these values and rptr_bin; with rptr_bin=0: rfill=0, rempty=1, ralmost_empty=1.
- Sync chain: stage[0]<=wptr, stage[i]<=stage[i-1]; rsync_ptr=stage[SYNC_STAGES-1].
  - wptr change to rsync_ptr: SYNC_STAGES edges.
- Decode stage (registered, one edge after rsync_ptr):
  - rsync_bin[PW-1]=g[PW-1]; rsync_bin[i]=rsync_bin[i+1]^g[i], where g=rsync_ptr.
  - gprev<=rsync_ptr in the same edge.
  - Total wptr to rsync_bin latency: SYNC_STAGES+1 edges.
- wptr_adv: registered, <= (rsync_ptr != gprev).
  - It is high in exactly the cycle rsync_bin first shows the new value.
  - Held wptr gives a single pulse.
- Fill (combinational from registered rsync_bin and the current rptr_bin):
  - rfill = (rsync_bin - rptr_bin) mod 2^PW.
  - rempty = (rsync_bin == rptr_bin).
  - ralmost_empty = (rfill <= AE_THRESH).
  - Wrap-around is handled purely by modulo arithmetic; no clamping.
  - rfill > DEPTH is illegal upstream; it is reported as computed, not saturated.
- Gray monitor: viol = popcount(rsync_ptr ^ gprev) > 1, evaluated each cycle.
  - gray_err next state: set if viol; else clear if clr_err; else hold.
  - Set wins over a simultaneous clr_err.
  - gray_err rises with the same edge that loads the offending value into rsync_bin.
  - Zero- and single-bit changes never set it.
- No enable input; the block samples every r_clk edge.
- The block never back-pressures. Reader stalling on rempty is the consumer's responsibility.

Test Plan:
1. Reset, DEPTH=8, SYNC_STAGES=2, wptr=0, rptr_bin=0 -> rsync_ptr=0, rsync_bin=0, rfill=0, rempty=1, ralmost_empty=1, wptr_adv=0, gray_err=0.
2. wptr 0000->0001 before edge 1 -> edge 2: rsync_ptr=0001; edge 3: rsync_bin=1, wptr_adv=1 for one cycle, rfill=1, rempty=0, ralmost_empty=1 (AE_THRESH=1). Holding wptr gives no further pulse.
3. Full-range walk, wptr=Gray(n), n=0..16, stepped every 4 cycles.
   - rptr_bin=0 until n=8: rfill=8 with wptr=1100.
   - Then rptr_bin=8, wptr wraps 15->0 (1000->0000): rfill=8; rptr_bin=0 gives rempty=1.
   - gray_err stays 0 throughout.
4. Gray violation and clear:
   - wptr 0000->0011 -> gray_err=1 at edge 3 and stays 1 after wptr returns to legal steps.
   - clr_err pulse -> gray_err=0 next edge.
   - clr_err held while injecting 0011->0000 -> gray_err=1 (set wins).
5. SYNC_STAGES=3, DEPTH=16 -> wptr step reaches rsync_ptr at edge 3 and rsync_bin/wptr_adv at edge 4. 5-bit pointer wrap: rsync_bin=0, rptr_bin=16 gives rfill=16.
6. rst_n asserted between edges mid-stream (rsync_bin=5) -> all registered outputs 0 before the next edge. After release with wptr=Gray(5)=0111 held: rsync_bin=5 after 3 edges, with one wptr_adv pulse.
